// File: rtl/wishbone_line_master.sv
// -----------------------------------------------------------------------------
// wishbone_line_master
//
// Connects one CPU datapath port (instruction fetch or data memory) to a
// Wishbone bus whose data path is a full cache line wide. Each CPU access is
// turned into a single-beat line transfer with the addressed word steered
// into its lane. A one-entry read line buffer answers repeat reads to the
// same line without touching the bus. An optional ACK timeout aborts a stuck
// access and reports it through cpu_err.
//
// Parameters
//   ADDR_BITS       CPU byte-address width
//   WORD_BITS       CPU word width (multiple of 8, power of 2)
//   LINE_BITS       bus line width (power-of-2 multiple of WORD_BITS)
//   BUFFER_EN       1 = line buffer enabled, 0 = every access uses the bus
//   TIMEOUT_CYCLES  BUS cycles without ACK before abort, 0 = never abort
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cpu_req         level request, held until cpu_resp
//   cpu_we          1 = write
//   cpu_addr        byte address (sub-word bits ignored)
//   cpu_wdata       write word
//   cpu_be          write byte enables
//   buf_inv         pulse, invalidates the line buffer
//   cpu_rdata       read word, valid with cpu_resp
//   cpu_resp        one-cycle completion pulse
//   cpu_err         qualifies cpu_resp: access timed out
//   wb_adr          line address
//   wb_dat_m        write line (CPU word replicated in every lane)
//   wb_dat_s        read line from the slave
//   wb_sel          byte selects
//   wb_we, wb_stb, wb_cyc  Wishbone control
//   wb_ack          slave acknowledge
// -----------------------------------------------------------------------------
module wishbone_line_master #(
   parameter int ADDR_BITS      = 16,
   parameter int WORD_BITS      = 16,
   parameter int LINE_BITS      = 128,
   parameter int BUFFER_EN      = 1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      cpu_req,
   input  logic                                      cpu_we,
   input  logic [ADDR_BITS-1:0]                      cpu_addr,
   input  logic [WORD_BITS-1:0]                      cpu_wdata,
   input  logic [WORD_BITS/8-1:0]                    cpu_be,
   input  logic                                      buf_inv,
   output logic [WORD_BITS-1:0]                      cpu_rdata,
   output logic                                      cpu_resp,
   output logic                                      cpu_err,
   output logic [ADDR_BITS-$clog2(LINE_BITS/8)-1:0]  wb_adr,
   output logic [LINE_BITS-1:0]                      wb_dat_m,
   input  logic [LINE_BITS-1:0]                      wb_dat_s,
   output logic [LINE_BITS/8-1:0]                    wb_sel,
   output logic                                      wb_we,
   output logic                                      wb_stb,
   output logic                                      wb_cyc,
   input  logic                                      wb_ack
);

   localparam int WB      = WORD_BITS / 8;
   localparam int LB      = LINE_BITS / 8;
   localparam int OFF     = $clog2(LB);
   localparam int WOFF    = $clog2(WB);
   localparam int IDXW    = OFF - WOFF;
   localparam int NW      = LINE_BITS / WORD_BITS;
   localparam int TAGW    = ADDR_BITS - OFF;
   localparam int TOW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_t                 r_state;
   logic                   r_cyc;
   logic                   r_we;
   logic [TAGW-1:0]        r_adr;
   logic [LB-1:0]          r_sel;
   logic [LINE_BITS-1:0]   r_dat_m;
   logic [WORD_BITS-1:0]   r_rdata;
   logic                   r_resp;
   logic                   r_err;
   logic [IDXW-1:0]        r_idx;
   logic [TOW-1:0]         r_to;

   // Line buffer
   logic                   r_valid;
   logic [TAGW-1:0]        r_tag;
   logic [LINE_BITS-1:0]   r_buf;

   // Next-state values
   state_t                 w_state_nxt;
   logic                   w_cyc_nxt;
   logic                   w_we_nxt;
   logic [TAGW-1:0]        w_adr_nxt;
   logic [LB-1:0]          w_sel_nxt;
   logic [LINE_BITS-1:0]   w_dat_m_nxt;
   logic [WORD_BITS-1:0]   w_rdata_nxt;
   logic                   w_resp_nxt;
   logic                   w_err_nxt;
   logic [IDXW-1:0]        w_idx_nxt;
   logic [TOW-1:0]         w_to_nxt;

   // Request decode
   logic [IDXW-1:0]        w_idx;
   logic [TAGW-1:0]        w_tag;
   logic [WB-1:0]          w_sel_word;
   logic [LB-1:0]          w_sel;
   logic [WORD_BITS-1:0]   w_buf_word;
   logic [WORD_BITS-1:0]   w_ack_word;
   logic                   w_hit;
   logic                   w_to_expire;
   logic                   w_fill;
   logic                   w_unused_lsb;

   assign w_idx      = cpu_addr[OFF-1:WOFF];
   assign w_tag      = cpu_addr[ADDR_BITS-1:OFF];
   assign w_sel_word = cpu_we ? cpu_be : '1;

   // Sub-word address bits carry no meaning for a word-aligned port.
   assign w_unused_lsb = ^(cpu_addr & ADDR_BITS'((1 << WOFF) - 1));

   assign w_hit = (BUFFER_EN != 0) && r_valid && !cpu_we && (r_tag == w_tag);

   // Abort fires on the BUS cycle whose count reaches TIMEOUT_CYCLES.
   assign w_to_expire = (TIMEOUT_CYCLES != 0) && (r_to == TOW'(TO_LAST));

   assign w_fill = (r_state == ST_BUS) && wb_ack && !r_we;

   // Lane steering: word selects on the request side, word extraction from
   // the buffer (hit path) and from the returned line (miss path).
   always_comb begin
      w_sel      = '0;
      w_buf_word = '0;
      w_ack_word = '0;
      for (int unsigned i = 0; i < NW; i++) begin
         if (w_idx == IDXW'(i)) begin
            w_sel[i*WB +: WB] = w_sel_word;
            w_buf_word        = r_buf[i*WORD_BITS +: WORD_BITS];
         end
         if (r_idx == IDXW'(i)) begin
            w_ack_word = wb_dat_s[i*WORD_BITS +: WORD_BITS];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_cyc;
      w_we_nxt    = r_we;
      w_adr_nxt   = r_adr;
      w_sel_nxt   = r_sel;
      w_dat_m_nxt = r_dat_m;
      w_rdata_nxt = r_rdata;
      w_resp_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_idx_nxt   = r_idx;
      w_to_nxt    = r_to;

      case (r_state)
         ST_IDLE: begin
            if (cpu_req) begin
               if (w_hit) begin
                  w_rdata_nxt = w_buf_word;
                  w_resp_nxt  = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cyc_nxt   = 1'b1;
                  w_we_nxt    = cpu_we;
                  w_adr_nxt   = w_tag;
                  w_sel_nxt   = w_sel;
                  w_dat_m_nxt = {NW{cpu_wdata}};
                  w_idx_nxt   = w_idx;
                  w_to_nxt    = '0;
                  w_state_nxt = ST_BUS;
               end
            end
         end

         ST_BUS: begin
            if (wb_ack) begin
               w_cyc_nxt   = 1'b0;
               w_resp_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
               if (!r_we) begin
                  w_rdata_nxt = w_ack_word;
               end
            end else if (w_to_expire) begin
               w_cyc_nxt   = 1'b0;
               w_resp_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_to_nxt = r_to + 1'b1;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cyc   <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_sel   <= '0;
         r_dat_m <= '0;
         r_rdata <= '0;
         r_resp  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_to    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cyc   <= w_cyc_nxt;
         r_we    <= w_we_nxt;
         r_adr   <= w_adr_nxt;
         r_sel   <= w_sel_nxt;
         r_dat_m <= w_dat_m_nxt;
         r_rdata <= w_rdata_nxt;
         r_resp  <= w_resp_nxt;
         r_err   <= w_err_nxt;
         r_idx   <= w_idx_nxt;
         r_to    <= w_to_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Line buffer
   // ---------------------------------------------------------------------------
   // Tag/valid: buf_inv is applied last so it wins over a same-cycle fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
      end else begin
         if (w_fill) begin
            r_tag   <= r_adr;
            r_valid <= (BUFFER_EN != 0);
         end
         if (buf_inv) begin
            r_valid <= 1'b0;
         end
      end
   end

   // Line data needs no reset: it is never observed while r_valid is low.
   // Write-through merge reuses the registered bus selects and replicated
   // write data, which already hold the enabled bytes in their line lanes.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_buf <= wb_dat_s;
      end else if ((r_state == ST_BUS) && wb_ack && r_we && r_valid && (r_tag == r_adr)) begin
         for (int unsigned b = 0; b < LB; b++) begin
            if (r_sel[b]) begin
               r_buf[b*8 +: 8] <= r_dat_m[b*8 +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cpu_rdata = r_rdata;
   assign cpu_resp  = r_resp;
   assign cpu_err   = r_err;
   assign wb_adr    = r_adr;
   assign wb_dat_m  = r_dat_m;
   assign wb_sel    = r_sel;
   assign wb_we     = r_we;
   assign wb_stb    = r_cyc;
   assign wb_cyc    = r_cyc;

endmodule

// File: tb/tb_wishbone_line_master.sv
module tb_wishbone_line_master;

   logic           clk = 1'b0;
   logic           rst;
   logic           cpu_req;
   logic           cpu_we;
   logic [15:0]    cpu_addr;
   logic [15:0]    cpu_wdata;
   logic [1:0]     cpu_be;
   logic           buf_inv;
   logic [15:0]    cpu_rdata;
   logic           cpu_resp;
   logic           cpu_err;
   logic [11:0]    wb_adr;
   logic [127:0]   wb_dat_m;
   logic [127:0]   wb_dat_s;
   logic [15:0]    wb_sel;
   logic           wb_we;
   logic           wb_stb;
   logic           wb_cyc;
   logic           wb_ack;

   wishbone_line_master #(
      .ADDR_BITS(16),
      .WORD_BITS(16),
      .LINE_BITS(128),
      .BUFFER_EN(1),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be),
      .buf_inv(buf_inv),
      .cpu_rdata(cpu_rdata),
      .cpu_resp(cpu_resp),
      .cpu_err(cpu_err),
      .wb_adr(wb_adr),
      .wb_dat_m(wb_dat_m),
      .wb_dat_s(wb_dat_s),
      .wb_sel(wb_sel),
      .wb_we(wb_we),
      .wb_stb(wb_stb),
      .wb_cyc(wb_cyc),
      .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [127:0] LINE1 = 128'h1007_1006_1005_1004_BEEF_1002_1001_1000;
   localparam logic [127:0] LINE2 = 128'h2777_2666_2555_2444_2333_2222_2111_2000;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CPU access. Expected response is queued when the request is driven
   // and popped when cpu_resp appears. The slave raises ACK in the
   // ack_after-th STB cycle (0 = never).
   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input int ack_after, input logic [127:0] line,
                         input logic inv_at_ack, input logic [15:0] exp_sel, input int exp_bus,
                         input logic [15:0] exp_rdata, input logic exp_err);
      exp_t e;
      int   lat;
      int   bus;
      bit   done;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_be    = be;
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      sb.push_back(e);
      lat  = 0;
      bus  = 0;
      done = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         wb_ack  = 1'b0;
         buf_inv = 1'b0;
         if (wb_stb) begin
            bus++;
            check("cyc_with_stb", 128'(wb_cyc), 128'(1'b1));
            check("adr", 128'(wb_adr), 128'(addr[15:4]));
            check("sel", 128'(wb_sel), 128'(exp_sel));
            check("we", 128'(wb_we), 128'(we));
            if (we) check("dat_m", wb_dat_m, {8{wdata}});
            if (bus == ack_after) begin
               wb_ack   = 1'b1;
               wb_dat_s = line;
               buf_inv  = inv_at_ack;
            end
         end
         if (cpu_resp) begin
            done    = 1'b1;
            cpu_req = 1'b0;
            check("stb_low_at_resp", 128'(wb_stb), 128'(1'b0));
            check("bus_cycles", 128'(bus), 128'(exp_bus));
            check("latency", 128'(lat), 128'((exp_bus == 0) ? 1 : exp_bus + 1));
            check("sb_nonempty", 128'(sb.size() > 0), 128'(1'b1));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("rdata", 128'(cpu_rdata), 128'(e.rdata));
               check("err", 128'(cpu_err), 128'(e.err));
            end
         end
      end
      check("resp_seen", 128'(done), 128'(1'b1));
      cpu_req = 1'b0;
      wb_ack  = 1'b0;
      buf_inv = 1'b0;
      sb.delete();
   endtask

   initial begin
      rst       = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_be    = '0;
      buf_inv   = 1'b0;
      wb_dat_s  = '0;
      wb_ack    = 1'b0;
      #2 rst = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_stb", 128'(wb_stb), 128'(1'b0));
      check("rst_cyc", 128'(wb_cyc), 128'(1'b0));
      check("rst_resp", 128'(cpu_resp), 128'(1'b0));
      check("rst_err", 128'(cpu_err), 128'(1'b0));
      check("rst_rdata", 128'(cpu_rdata), 128'(16'h0));
      check("rst_sel", 128'(wb_sel), 128'(16'h0));
      check("rst_adr", 128'(wb_adr), 128'(12'h0));
      rst = 1'b0;
      @(negedge clk);

      // Read miss, ACK in 3rd BUS cycle
      access(1'b0, 16'h1236, 16'h0, 2'b00, 3, LINE1, 1'b0, 16'h00C0, 3, 16'hBEEF, 1'b0);
      // Back-to-back read hit on the buffered line
      access(1'b0, 16'h1230, 16'h0, 2'b00, 1, LINE1, 1'b0, 16'h0000, 0, 16'h1000, 1'b0);
      // Write-through to the buffered line, then read it back from the buffer
      access(1'b1, 16'h1235, 16'hA5A5, 2'b11, 2, LINE1, 1'b0, 16'h0030, 2, 16'h1000, 1'b0);
      access(1'b0, 16'h1234, 16'h0, 2'b00, 1, LINE1, 1'b0, 16'h0000, 0, 16'hA5A5, 1'b0);
      // Slave never acknowledges: abort after 8 BUS cycles, rdata unchanged
      access(1'b0, 16'h7770, 16'h0, 2'b00, 0, LINE2, 1'b0, 16'h0003, 8, 16'hA5A5, 1'b1);
      // Buffer untouched by the abort
      access(1'b0, 16'h1234, 16'h0, 2'b00, 1, LINE1, 1'b0, 16'h0000, 0, 16'hA5A5, 1'b0);

      // Stray ACK while idle must not produce a response
      @(negedge clk);
      wb_ack = 1'b1;
      @(negedge clk);
      check("idle_ack_resp", 128'(cpu_resp), 128'(1'b0));
      check("idle_ack_stb", 128'(wb_stb), 128'(1'b0));
      @(negedge clk);
      wb_ack = 1'b0;
      check("idle_ack_resp2", 128'(cpu_resp), 128'(1'b0));

      // Invalidate coinciding with a read ACK: data returned, line not kept
      access(1'b0, 16'h2002, 16'h0, 2'b00, 2, LINE2, 1'b1, 16'h000C, 2, 16'h2111, 1'b0);
      access(1'b0, 16'h2002, 16'h0, 2'b00, 1, LINE2, 1'b0, 16'h000C, 1, 16'h2111, 1'b0);
      access(1'b0, 16'h200E, 16'h0, 2'b00, 1, LINE2, 1'b0, 16'h0000, 0, 16'h2777, 1'b0);
      // Write to another line must not disturb the buffered one
      access(1'b1, 16'h3000, 16'h1234, 2'b01, 1, LINE2, 1'b0, 16'h0001, 1, 16'h2777, 1'b0);
      access(1'b0, 16'h2000, 16'h0, 2'b00, 1, LINE2, 1'b0, 16'h0000, 0, 16'h2000, 1'b0);

      // Reset during the 2nd BUS cycle
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h4562;
      @(negedge clk);
      check("pre_rst_stb1", 128'(wb_stb), 128'(1'b1));
      @(negedge clk);
      check("pre_rst_stb2", 128'(wb_stb), 128'(1'b1));
      rst = 1'b1;
      #1;
      check("rst_async_stb", 128'(wb_stb), 128'(1'b0));
      check("rst_async_cyc", 128'(wb_cyc), 128'(1'b0));
      check("rst_async_resp", 128'(cpu_resp), 128'(1'b0));
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_resp", 128'(cpu_resp), 128'(1'b0));
         check("post_rst_no_stb", 128'(wb_stb), 128'(1'b0));
      end
      // Buffer was invalidated by reset: previously buffered lines miss
      access(1'b0, 16'h2000, 16'h0, 2'b00, 1, LINE2, 1'b0, 16'h0003, 1, 16'h2000, 1'b0);
      access(1'b0, 16'h1230, 16'h0, 2'b00, 1, LINE1, 1'b0, 16'h0003, 1, 16'h1000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
